sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_ctrl_pkg.sv | 17 +
 rtl/sync_fifo_ctrl_ram.sv | 57 +++++
 rtl/sync_fifo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers for the FWFT FIFO controller and its RAM.
// Level/count widths and RAM depth derive from ADDR_WIDTH.
package sync_fifo_ctrl_pkg;

  function automatic int lvl_w(input int aw);
    return aw + 2;
  endfunction

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int ram_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_ram.sv
// Inferable dual-port block RAM: one write port, one read port.
// Optional second output register (REGRAM) and optional read enable.
module infer_blkram
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int D_WIDTH         = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int ONECLOCK        = 1,
  parameter int REGRAM          = 0,
  parameter int USE_READ_ENABLE = 1
) (
  input  logic                  wclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0]    wdata,
  input  logic                  rclk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  reg_ce,
  output logic [D_WIDTH-1:0]    rdata
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] dout_q;
  logic [D_WIDTH-1:0] out_q;
  logic               rd_clk;
  logic               rd_fire;

  assign rd_clk  = (ONECLOCK != 0) ? wclk : rclk;
  assign rd_fire = re || (USE_READ_ENABLE == 0);

  // Array write port.
  always_ff @(posedge wclk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port output register.
  always_ff @(posedge rd_clk) begin
    if (rd_fire) begin
      dout_q <= mem_q[raddr];
    end
  end

  // Optional pipeline register after the read port.
  always_ff @(posedge rd_clk) begin
    if (reg_ce) begin
      out_q <= dout_q;
    end
  end

  assign rdata = (REGRAM != 0) ? out_q : dout_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FWFT synchronous FIFO: RAM output register is the head stage.
// Optional XOR checksum guard under SYNC_FIFO_CHECKSUM_EN.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [D_WIDTH-1:0]           wr_data,
  output logic                         full,
  input  logic                         rd_en,
  output logic [D_WIDTH-1:0]           rd_data,
  output logic                         rd_valid,
  output logic [lvl_w(ADDR_WIDTH)-1:0] level,
  output logic                         wr_err,
  output logic                         rd_err
`ifdef SYNC_FIFO_CHECKSUM_EN
  ,
  output logic                         chk_err
`endif
);

  localparam int LW = lvl_w(ADDR_WIDTH);
  localparam int CW = cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH = CW'(ram_depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic                  full_q, full_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic push_ok;
  logic pop_ok;
  logic ram_we;
  logic ram_re;

  // Next-state for pointers, count, head valid and flags.
  always_comb begin
    push_ok  = wr_en && !full_q;
    pop_ok   = rd_en && vld_q;
    ram_we   = push_ok && !flush;
    ram_re   = (cnt_q != '0) && (!vld_q || pop_ok) && !flush;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      vld_d  = 1'b0;
    end else begin
      if (ram_we) begin
        wptr_d = wptr_q + ADDR_WIDTH'(1);
      end
      if (ram_re) begin
        rptr_d = rptr_q + ADDR_WIDTH'(1);
      end
      cnt_d = cnt_q + CW'(ram_we) - CW'(ram_re);
      if (ram_re) begin
        vld_d = 1'b1;
      end else if (pop_ok) begin
        vld_d = 1'b0;
      end
      wr_err_d = wr_en && full_q;
      rd_err_d = rd_en && !vld_q;
    end
    full_d  = (cnt_d == DEPTH);
    level_d = LW'(cnt_d) + LW'(vld_d);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      full_q   <= 1'b0;
      level_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      full_q   <= full_d;
      level_q  <= level_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign full     = full_q;
  assign rd_valid = vld_q;
  assign level    = level_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

  infer_blkram #(
    .D_WIDTH        (D_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .ONECLOCK       (1),
    .REGRAM         (0),
    .USE_READ_ENABLE(1)
  ) u_ram (
    .wclk  (clk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (wr_data),
    .rclk  (clk),
    .re    (ram_re),
    .raddr (rptr_q),
    .reg_ce(1'b0),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_CHECKSUM_EN
  logic [D_WIDTH-1:0] wr_sum_q, wr_sum_d;
  logic [D_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic               chk_q, chk_d;

  // Running XOR of pushed/popped words; sticky error on drain mismatch.
  always_comb begin
    wr_sum_d = wr_sum_q;
    rd_sum_d = rd_sum_q;
    chk_d    = chk_q;
    if (flush) begin
      wr_sum_d = '0;
      rd_sum_d = '0;
      chk_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_sum_d = wr_sum_q ^ wr_data;
      end
      if (pop_ok) begin
        rd_sum_d = rd_sum_q ^ rd_data;
      end
      if ((level_d == '0) && (level_q != '0) &&
          (wr_sum_d != rd_sum_d)) begin
        chk_d = 1'b1;
      end
    end
  end

  // Checksum state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sum_q <= '0;
      rd_sum_q <= '0;
      chk_q    <= 1'b0;
    end else begin
      wr_sum_q <= wr_sum_d;
      rd_sum_q <= rd_sum_d;
      chk_q    <= chk_d;
    end
  end

  assign chk_err = chk_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (ADDR_WIDTH=5, D_WIDTH=32).
// Checksum scenario runs only with SYNC_FIFO_CHECKSUM_EN.
module tb_sync_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [6:0]  level;
  logic        wr_err;
  logic        rd_err;
`ifdef SYNC_FIFO_CHECKSUM_EN
  logic        chk_err;
`endif

  int n_run;
  int n_fail;

  sync_fifo_ctrl #(
    .D_WIDTH   (32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .level   (level),
    .wr_err  (wr_err),
    .rd_err  (rd_err)
`ifdef SYNC_FIFO_CHECKSUM_EN
    ,
    .chk_err (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run = n_run + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // single push latency
    push(32'hA5A5_0001);
    check("lat_t1_valid", 32'(rd_valid), 32'd0);
    check("lat_t1_level", 32'(level), 32'd1);
    tick();
    check("lat_t2_valid", 32'(rd_valid), 32'd1);
    check("lat_t2_data", rd_data, 32'hA5A5_0001);
    check("lat_t2_level", 32'(level), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("lat_pop_valid", 32'(rd_valid), 32'd0);
    check("lat_pop_level", 32'(level), 32'd0);

    // fill to capacity
    for (int i = 0; i < 33; i++) begin
      push(32'(i));
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_full", 32'(full), 32'(i == 32));
    end
    check("fill_err0", 32'(wr_err), 32'd0);
    push(32'd33);
    check("ovf_wr_err", 32'(wr_err), 32'd1);
    check("ovf_level", 32'(level), 32'd33);
    tick();
    check("ovf_err_clr", 32'(wr_err), 32'd0);

    // drain at one word per cycle
    rd_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", rd_data, 32'(i));
      tick();
    end
    check("drain_empty", 32'(rd_valid), 32'd0);
    check("drain_level", 32'(level), 32'd0);
    check("drain_rd_err0", 32'(rd_err), 32'd0);
    tick();
    rd_en = 1'b0;
    check("udf_rd_err", 32'(rd_err), 32'd1);
    tick();
    check("udf_err_clr", 32'(rd_err), 32'd0);
`ifdef SYNC_FIFO_CHECKSUM_EN
    check("chk_clean", 32'(chk_err), 32'd0);
`endif

    // streaming at level 4
    for (int i = 0; i < 4; i++) begin
      push(32'(100 + i));
    end
    check("strm_lvl0", 32'(level), 32'd4);
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 32'(104 + i);
      check("strm_data", rd_data, 32'(100 + i));
      tick();
      check("strm_level", 32'(level), 32'd4);
    end
    wr_en = 1'b0;
    check("strm_wr_err", 32'(wr_err), 32'd0);
    check("strm_rd_err", 32'(rd_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("strm_tail", rd_data, 32'(200 + i));
      tick();
    end
    rd_en = 1'b0;
    check("strm_end_lvl", 32'(level), 32'd0);

    // push while full and popping: push rejected
    for (int i = 0; i < 33; i++) begin
      push(32'h400 + 32'(i));
    end
    check("fp_full", 32'(full), 32'd1);
    check("fp_head", rd_data, 32'h400);
    wr_en   = 1'b1;
    wr_data = 32'hBAD;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("fp_wr_err", 32'(wr_err), 32'd1);
    check("fp_level", 32'(level), 32'd32);
    check("fp_full_clr", 32'(full), 32'd0);
    check("fp_next", rd_data, 32'h401);

    // flush with concurrent push
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl0_level", 32'(level), 32'd0);
    for (int i = 0; i < 10; i++) begin
      push(32'h300 + 32'(i));
    end
    check("fl_pre_lvl", 32'(level), 32'd10);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'hDEAD;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_level", 32'(level), 32'd0);
    check("fl_valid", 32'(rd_valid), 32'd0);
    check("fl_full", 32'(full), 32'd0);
    tick();
    check("fl_discard", 32'(level), 32'd0);
    push(32'h77);
    tick();
    check("fl_after_v", 32'(rd_valid), 32'd1);
    check("fl_after_d", rd_data, 32'h77);
    check("fl_after_l", 32'(level), 32'd1);

    // asynchronous reset mid-operation
    push(32'h88);
    push(32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_hold", 32'(level), 32'd0);

`ifdef SYNC_FIFO_CHECKSUM_EN
    // corrupted head word must trip the checksum
    for (int i = 0; i < 8; i++) begin
      push(32'h500 + 32'(i));
    end
    tick();
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        force dut.rd_data = 32'h0000_0504;
      end
      tick();
      if (i == 5) begin
        release dut.rd_data;
      end
    end
    rd_en = 1'b0;
    check("cs_level", 32'(level), 32'd0);
    check("cs_err", 32'(chk_err), 32'd1);
    repeat (3) tick();
    check("cs_sticky", 32'(chk_err), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cs_flush", 32'(chk_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
